// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings for the pipeline sequencer
package pipe_ctrl_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_INVALID = 32'h0000_000a;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALL   = 2'd1,
    ST_RECOVER = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - stall/flush request and control bundle between core stages and sequencer
interface pipe_ctrl_if;

  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;

  modport master (
    output stallreq_from_id, stallreq_from_ex, excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc
  );

  modport slave (
    input  stallreq_from_id, stallreq_from_ex, excepttype_i, cp0_epc_i,
    output stall, flush, new_pc
  );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// rtl/pipe_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != {W{1'b1}})) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - merges ID/EX stall requests and MEM exceptions into stall/flush/new_pc
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int          MAX_STALL  = 64,
  parameter int          CNT_W      = 7
) (
  input  logic          clk,
  input  logic          rst,
  pipe_ctrl_if.slave    bus,
  output logic          stall_timeout_o,
  output logic [31:0]   perf_stall_cyc_o,
  output logic [15:0]   perf_flush_cnt_o
);

  pipe_state_t      state;
  logic             exc;
  logic [5:0]       stall_c;
  logic             flush_c;
  logic [31:0]      new_pc_c;
  logic [CNT_W-1:0] stall_cnt;
  logic             stalled;

  assign exc = (bus.excepttype_i != EXC_NONE);

  // Zero-latency outputs: downstream registers sample them in this same cycle.
  always_comb begin
    stall_c  = STALL_NONE;
    flush_c  = 1'b0;
    new_pc_c = '0;
    if (rst) begin
      if (exc) begin
        flush_c  = 1'b1;
        new_pc_c = (bus.excepttype_i == EXC_ERET) ? bus.cp0_epc_i : EXC_VECTOR;
      end else if (state != ST_RECOVER) begin
        if (bus.stallreq_from_ex)
          stall_c = STALL_EX;
        else if (bus.stallreq_from_id)
          stall_c = STALL_ID;
      end
    end
  end

  assign bus.stall  = stall_c;
  assign bus.flush  = flush_c;
  assign bus.new_pc = new_pc_c;
  assign stalled    = (stall_c != STALL_NONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_RUN;
    end else if (exc) begin
      state <= ST_RECOVER;
    end else if (state == ST_RECOVER) begin
      state <= ST_RUN;
    end else if (bus.stallreq_from_ex || bus.stallreq_from_id) begin
      state <= ST_STALL;
    end else begin
      state <= ST_RUN;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stalled),
    .clr   (!stalled || flush_c),
    .value (stall_cnt)
  );

  // Counter holds the stalled cycles already completed, so MAX_STALL-1 plus this one trips it.
  always_ff @(posedge clk) begin
    if (!rst)
      stall_timeout_o <= 1'b0;
    else if (stalled && (stall_cnt >= CNT_W'(MAX_STALL - 1)))
      stall_timeout_o <= 1'b1;
  end

  sat_counter #(.W(32)) u_perf_stall (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_c[2]),
    .clr   (1'b0),
    .value (perf_stall_cyc_o)
  );

  sat_counter #(.W(16)) u_perf_flush (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_c),
    .clr   (1'b0),
    .value (perf_flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall_timeout_o;
  logic [31:0] perf_stall_cyc_o;
  logic [15:0] perf_flush_cnt_o;
  int          errors;
  int          checks;

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .EXC_VECTOR (32'h0000_0020),
    .MAX_STALL  (4),
    .CNT_W      (7)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .stall_timeout_o  (stall_timeout_o),
    .perf_stall_cyc_o (perf_stall_cyc_o),
    .perf_flush_cnt_o (perf_flush_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic ex, input logic [31:0] et, input logic [31:0] epc);
    bus.stallreq_from_id = id;
    bus.stallreq_from_ex = ex;
    bus.excepttype_i     = et;
    bus.cp0_epc_i        = epc;
    #1;
  endtask

  task automatic check_ctrl(input string tag, input logic [5:0] st, input logic fl, input logic [31:0] pc);
    check({tag, ".stall"}, 32'(bus.stall), 32'(st));
    check({tag, ".flush"}, 32'(bus.flush), 32'(fl));
    check({tag, ".new_pc"}, bus.new_pc, pc);
  endtask

  initial begin
    errors = 0;
    checks = 0;

    rst = 1'b0;
    drive(1'b1, 1'b1, EXC_SYSCALL, 32'h0000_5555);
    for (int i = 0; i < 3; i++) begin
      check_ctrl("reset_hold", 6'b000000, 1'b0, 32'h0);
      tick();
    end
    check("reset_perf_stall", perf_stall_cyc_o, 32'd0);
    check("reset_perf_flush", 32'(perf_flush_cnt_o), 32'd0);
    check("reset_timeout", 32'(stall_timeout_o), 32'd0);

    rst = 1'b1;
    drive(1'b0, 1'b0, EXC_NONE, 32'h0);
    check_ctrl("idle", 6'b000000, 1'b0, 32'h0);
    tick();

    drive(1'b1, 1'b0, EXC_NONE, 32'h0);
    check_ctrl("id_stall", 6'b000111, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, EXC_NONE, 32'h0);
    check("id_perf", perf_stall_cyc_o, 32'd1);
    check("id_release", 32'(bus.stall), 32'h0);
    tick();

    drive(1'b1, 1'b1, EXC_NONE, 32'h0);
    check("both_stall", 32'(bus.stall), 32'h0f);
    tick();
    drive(1'b1, 1'b0, EXC_NONE, 32'h0);
    check("id_after_ex", 32'(bus.stall), 32'h07);
    tick();
    drive(1'b0, 1'b0, EXC_NONE, 32'h0);
    check("both_perf", perf_stall_cyc_o, 32'd3);
    tick();

    drive(1'b0, 1'b1, EXC_NONE, 32'h0);
    check("ex_stall", 32'(bus.stall), 32'h0f);
    tick();
    drive(1'b0, 1'b1, EXC_SYSCALL, 32'h0000_9999);
    check_ctrl("syscall", 6'b000000, 1'b1, 32'h0000_0020);
    tick();
    drive(1'b0, 1'b1, EXC_NONE, 32'h0);
    check_ctrl("recover_mask", 6'b000000, 1'b0, 32'h0);
    check("syscall_perf_flush", 32'(perf_flush_cnt_o), 32'd1);
    tick();
    check("after_recover", 32'(bus.stall), 32'h0f);
    tick();
    drive(1'b0, 1'b0, EXC_NONE, 32'h0);
    check("ex_perf", perf_stall_cyc_o, 32'd5);
    tick();

    drive(1'b0, 1'b0, EXC_ERET, 32'h0000_1234);
    check_ctrl("eret", 6'b000000, 1'b1, 32'h0000_1234);
    tick();
    check("eret_perf_flush", 32'(perf_flush_cnt_o), 32'd2);
    drive(1'b1, 1'b0, EXC_INT, 32'h0000_1234);
    check_ctrl("exc_in_recover", 6'b000000, 1'b1, 32'h0000_0020);
    tick();
    drive(1'b1, 1'b0, EXC_NONE, 32'h0);
    check("recover_again", 32'(bus.stall), 32'h0);
    tick();
    check("id_post_recover", 32'(bus.stall), 32'h07);
    tick();
    drive(1'b0, 1'b0, EXC_NONE, 32'h0);
    check("int_perf_flush", 32'(perf_flush_cnt_o), 32'd3);
    check("pre_wd_timeout", 32'(stall_timeout_o), 32'd0);
    tick();

    drive(1'b0, 1'b1, EXC_NONE, 32'h0);
    for (int i = 1; i <= 6; i++) begin
      check("wd_stall", 32'(bus.stall), 32'h0f);
      tick();
      check($sformatf("wd_timeout_%0d", i), 32'(stall_timeout_o), (i >= 4) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 1'b0, EXC_NONE, 32'h0);
    tick();
    tick();
    check("wd_sticky", 32'(stall_timeout_o), 32'd1);
    check("wd_perf", perf_stall_cyc_o, 32'd12);

    drive(1'b0, 1'b1, EXC_NONE, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check_ctrl("reset_mid_stall", 6'b000000, 1'b0, 32'h0);
    tick();
    check("rst_timeout", 32'(stall_timeout_o), 32'd0);
    check("rst_perf_stall", perf_stall_cyc_o, 32'd0);
    rst = 1'b1;
    drive(1'b0, 1'b0, EXC_NONE, 32'h0);
    check("post_rst_idle", 32'(bus.stall), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
